// File: rtl/modn_count_sched_pkg.sv
// Shared types and width helpers for the mod-N burst scheduler.
package modn_count_sched_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_DONE
    } state_t;

    // A modulus of 1 still needs a one-bit phase register.
    function automatic int phase_w(input int mod);
        return (mod > 1) ? $clog2(mod) : 1;
    endfunction

    localparam int MOD_DEF = 6;
    localparam int PHASE_W = phase_w(MOD_DEF);

endpackage

// File: rtl/modn_count_sched_if.sv
// Requester/scheduler bus: burst requests in, grants, acks and phase out.
interface modn_count_sched_if
    import modn_count_sched_pkg::*;
#(
    parameter int NREQ  = 2,
    parameter int MOD   = 6,
    parameter int LEN_W = 4
);
    localparam int PW = phase_w(MOD);

    logic [NREQ-1:0]       req;
    logic [NREQ*LEN_W-1:0] len;
    logic                  abort;
    logic [NREQ-1:0]       gnt;
    logic [NREQ-1:0]       ack;
    logic                  busy;
    logic                  cnt_en;
    logic [PW-1:0]         phase;
    logic                  done;
    logic                  aborted;

    modport master (
        output req, len, abort,
        input  gnt, ack, busy, cnt_en, phase, done, aborted
    );

    modport slave (
        input  req, len, abort,
        output gnt, ack, busy, cnt_en, phase, done, aborted
    );

endinterface

// File: rtl/modn_phase_ctr.sv
// Wrapping 0..MOD-1 phase counter with synchronous clear and step enable.
module modn_phase_ctr
    import modn_count_sched_pkg::*;
#(
    parameter int MOD = 6
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    i_clr,
    input  logic                    i_en,
    output logic [phase_w(MOD)-1:0] o_phase
);
    localparam int PW = phase_w(MOD);

    logic [PW-1:0] r_phase;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_phase <= '0;
        end else if (i_clr) begin
            r_phase <= '0;
        end else if (i_en) begin
            r_phase <= (r_phase == PW'(MOD - 1)) ? '0 : r_phase + 1'b1;
        end
    end

    assign o_phase = r_phase;

endmodule

// File: rtl/modn_count_sched.sv
// Round-robin scheduler granting fixed-length bursts of a shared mod-MOD phase counter.
module modn_count_sched
    import modn_count_sched_pkg::*;
#(
    parameter int NREQ  = 2,
    parameter int MOD   = 6,
    parameter int LEN_W = 4
) (
    input  logic              clk,
    input  logic              rst,
    modn_count_sched_if.slave bus
);
    localparam int IDX_W = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int PW    = phase_w(MOD);

    state_t           r_state;
    state_t           w_state_nxt;
    logic [NREQ-1:0]  r_gnt;
    logic [IDX_W-1:0] r_sel;
    logic [IDX_W-1:0] r_rr_last;
    logic [LEN_W-1:0] r_rem;
    logic             r_aborted;
    logic [IDX_W-1:0] w_sel;
    logic [LEN_W-1:0] w_len_sel;
    logic             w_clr;
    logic             w_en;
    logic [PW-1:0]    w_phase;

    // Lowest offset after the last winner takes priority.
    function automatic logic [IDX_W-1:0] rr_pick(input logic [NREQ-1:0] req,
                                                 input logic [IDX_W-1:0] last);
        logic [IDX_W-1:0] pick;
        int               idx;
        pick = last;
        for (int i = NREQ; i >= 1; i--) begin
            idx = (int'(last) + i) % NREQ;
            if (req[IDX_W'(idx)]) pick = IDX_W'(idx);
        end
        return pick;
    endfunction

    assign w_sel     = rr_pick(bus.req, r_rr_last);
    assign w_len_sel = bus.len[w_sel*LEN_W +: LEN_W];

    always_comb begin
        w_state_nxt = r_state;
        w_clr       = 1'b0;
        w_en        = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (|bus.req) begin
                    w_clr       = 1'b1;
                    w_state_nxt = (w_len_sel != '0) ? ST_RUN : ST_DONE;
                end
            end
            ST_RUN: begin
                // The last burst cycle holds the phase so DONE shows the final count.
                if (bus.abort || (r_rem <= LEN_W'(1))) begin
                    w_state_nxt = ST_DONE;
                end else begin
                    w_en = 1'b1;
                end
            end
            ST_DONE: w_state_nxt = ST_IDLE;
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= ST_IDLE;
            r_gnt     <= '0;
            r_sel     <= '0;
            r_rr_last <= IDX_W'(NREQ - 1);
            r_rem     <= '0;
            r_aborted <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            case (r_state)
                ST_IDLE: begin
                    if (|bus.req) begin
                        r_gnt     <= NREQ'(1) << w_sel;
                        r_sel     <= w_sel;
                        r_rem     <= w_len_sel;
                        r_aborted <= 1'b0;
                    end
                end
                ST_RUN: begin
                    if (w_en) r_rem <= r_rem - 1'b1;
                    r_aborted <= bus.abort;
                end
                ST_DONE: begin
                    r_gnt     <= '0;
                    r_rr_last <= r_sel;
                    r_aborted <= 1'b0;
                end
                default: begin
                    r_gnt <= '0;
                end
            endcase
        end
    end

    modn_phase_ctr #(.MOD(MOD)) u_phase_ctr (
        .clk     (clk),
        .rst     (rst),
        .i_clr   (w_clr),
        .i_en    (w_en),
        .o_phase (w_phase)
    );

    assign bus.gnt     = r_gnt;
    assign bus.ack     = (r_state == ST_DONE) ? r_gnt : '0;
    assign bus.done    = (r_state == ST_DONE);
    assign bus.busy    = (r_state != ST_IDLE);
    assign bus.cnt_en  = (r_state == ST_RUN);
    assign bus.aborted = r_aborted && (r_state == ST_DONE);
    assign bus.phase   = w_phase;

endmodule

// File: tb/tb_modn_count_sched.sv
// Scoreboard bench for modn_count_sched: burst-level reference model vs. observed bursts.
module tb_modn_count_sched;
    import modn_count_sched_pkg::*;

    localparam int NREQ  = 2;
    localparam int MOD   = 6;
    localparam int LEN_W = 4;
    localparam int LV_W  = NREQ * LEN_W;

    typedef struct {
        int idx;
        int n;
        bit ab;
    } exp_t;

    logic clk = 1'b0;
    logic rst;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   model_last = NREQ - 1;

    always #5 clk = ~clk;

    modn_count_sched_if #(.NREQ(NREQ), .MOD(MOD), .LEN_W(LEN_W)) bus ();

    modn_count_sched #(.NREQ(NREQ), .MOD(MOD), .LEN_W(LEN_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    task automatic check(input string name, input longint act, input longint req_v);
        n_checks++;
        if (act != req_v) begin
            n_fail++;
            $display("FAIL %s: got %0d, required %0d (t=%0t)", name, act, req_v, $time);
        end
    endtask

    // Burst-level model: round-robin winner, cycle count and abort flag.
    task automatic predict(input int mask, input logic [LV_W-1:0] lv,
                           input int abort_at, output exp_t e);
        int l;
        e.idx = -1;
        for (int k = 1; k <= NREQ; k++) begin
            int c;
            c = (model_last + k) % NREQ;
            if (e.idx < 0 && ((mask >> c) & 1) == 1) e.idx = c;
        end
        l = int'(lv[e.idx*LEN_W +: LEN_W]);
        if (abort_at >= 1 && abort_at <= l) begin
            e.n  = abort_at;
            e.ab = 1'b1;
        end else begin
            e.n  = l;
            e.ab = 1'b0;
        end
        model_last = e.idx;
    endtask

    task automatic run_to_done(input int abort_at);
        int c;
        bit seen;
        c    = 1;
        seen = 1'b0;
        for (int t = 0; t < 40; t++) begin
            if (bus.done) begin
                seen = 1'b1;
                break;
            end
            bus.abort = (c == abort_at);
            @(posedge clk);
            #1;
            bus.abort = 1'b0;
            c++;
        end
        if (!seen) check("done_timeout", 0, 1);
    endtask

    task automatic do_burst(input int mask, input logic [LV_W-1:0] lv, input int abort_at);
        exp_t e;
        @(posedge clk);
        #1;
        predict(mask, lv, abort_at, e);
        exp_q.push_back(e);
        bus.req = NREQ'(mask);
        bus.len = lv;
        @(posedge clk);
        #1;
        check("gnt_latency", bus.gnt, 1 << e.idx);
        bus.req = '0;
        bus.len = LV_W'($urandom);
        run_to_done(abort_at);
    endtask

    task automatic alternate(input int count, input logic [LV_W-1:0] lv);
        exp_t e;
        bit   seen;
        @(posedge clk);
        #1;
        for (int k = 0; k < count; k++) begin
            predict((1 << NREQ) - 1, lv, 0, e);
            exp_q.push_back(e);
        end
        bus.req = '1;
        bus.len = lv;
        for (int k = 0; k < count; k++) begin
            seen = 1'b0;
            for (int t = 0; t < 40; t++) begin
                @(posedge clk);
                #1;
                if (bus.done) begin
                    seen = 1'b1;
                    break;
                end
            end
            if (!seen) check("alt_done_timeout", 0, 1);
        end
        bus.req = '0;
    endtask

    // Monitor: assembles each observed burst and scores it against the queue.
    bit     in_burst   = 1'b0;
    bit     after_done = 1'b0;
    longint cur_gnt    = 0;
    int     ph[$];

    always @(negedge clk) begin
        exp_t e;
        bit   inv_ok;
        if (rst) begin
            in_burst   = 1'b0;
            after_done = 1'b0;
            ph.delete();
        end else begin
            inv_ok = $onehot0(bus.gnt) && ((bus.ack & ~bus.gnt) == '0)
                     && (bus.done == (|bus.ack)) && (!bus.cnt_en || bus.busy)
                     && (bus.busy == (bus.gnt != '0)) && (!bus.aborted || bus.done);
            check("invariants", inv_ok, 1);
            if (after_done) begin
                check("idle_after_done", {bus.gnt, bus.busy}, 0);
                after_done = 1'b0;
            end
            if (!in_burst && bus.gnt != '0) begin
                in_burst = 1'b1;
                cur_gnt  = bus.gnt;
                ph.delete();
            end
            if (in_burst && bus.gnt != cur_gnt) check("gnt_held", bus.gnt, cur_gnt);
            if (bus.cnt_en) ph.push_back(int'(bus.phase));
            if (bus.done) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_done", 1, 0);
                end else begin
                    e = exp_q.pop_front();
                    check("gnt", cur_gnt, 1 << e.idx);
                    check("ack", bus.ack, 1 << e.idx);
                    check("burst_cycles", ph.size(), e.n);
                    for (int k = 0; k < ph.size() && k < e.n; k++)
                        check("phase", ph[k], k % MOD);
                    check("aborted", bus.aborted, e.ab);
                    check("done_phase", bus.phase, (e.n == 0) ? 0 : (e.n - 1) % MOD);
                end
                in_burst   = 1'b0;
                after_done = 1'b1;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: run did not complete, required finish before 200000");
        $fatal(1, "timeout");
    end

    initial begin
        rst       = 1'b1;
        bus.req   = '0;
        bus.len   = '0;
        bus.abort = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_outputs", {bus.gnt, bus.ack, bus.busy, bus.cnt_en, bus.phase,
                                bus.done, bus.aborted}, 0);
        rst = 1'b0;
        @(posedge clk);
        #1;
        check("post_reset_idle", {bus.gnt, bus.busy, bus.phase}, 0);

        do_burst(1, 8'h03, 0);
        do_burst(1, 8'h08, 0);
        alternate(4, 8'h22);
        do_burst(2, 8'h05, 0);
        do_burst(1, 8'h0A, 4);
        do_burst(3, 8'h35, 1);

        // Reset in the second RUN cycle of a len=5 burst drops it silently.
        @(posedge clk);
        #1;
        bus.req = 2'b01;
        bus.len = 8'h05;
        @(posedge clk);
        #1;
        bus.req = '0;
        @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        check("midburst_reset", {bus.gnt, bus.ack, bus.busy, bus.cnt_en, bus.phase,
                                 bus.done, bus.aborted}, 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_last = NREQ - 1;
        do_burst(3, 8'h22, 0);

        for (int i = 0; i < 25; i++) begin
            int mask;
            int ab;
            mask = int'($urandom_range(1, (1 << NREQ) - 1));
            ab   = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 16)) : 0;
            do_burst(mask, LV_W'($urandom), ab);
        end

        repeat (5) @(posedge clk);
        #1;
        check("scoreboard_empty", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
